// File: rtl/incr_square_seq.sv
// Sequential (y+OFFSET)^2 / (y+OFFSET) unit with valid/ready handshakes.
// Uses a WIDTH-step shift-add multiplier instead of a full array multiplier.
module incr_square_seq #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] OFFSET = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             incovf_q, incovf_d;
    logic [WIDTH-1:0] out_d;
    logic             ovf_d;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc_sum;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        incovf_d = incovf_q;
        out_d    = out;
        ovf_d    = ovf;
        sum      = {1'b0, y} + {1'b0, OFFSET};
        acc_sum  = acc_q + (b_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    incovf_d = sum[WIDTH];
                    if (mode) begin
                        out_d   = sum[WIDTH-1:0];
                        ovf_d   = sum[WIDTH];
                        state_d = HOLD;
                    end else begin
                        mcand_d = PW'(sum[WIDTH-1:0]);
                        b_d     = sum[WIDTH-1:0];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // Fixed WIDTH steps; the last one publishes the product
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d   = acc_sum[WIDTH-1:0];
                    ovf_d   = incovf_q | (|acc_sum[PW-1:WIDTH]);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            incovf_q <= 1'b0;
            out      <= '0;
            ovf      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            incovf_q <= incovf_d;
            out      <= out_d;
            ovf      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_incr_square_seq.sv
// Randomized self-checking bench for incr_square_seq at WIDTH=32 and WIDTH=8.
module tb_incr_square_seq;

    logic        clk;
    logic        rst_n;

    logic        iv32, rdy32, m32, ov32, or32, f32;
    logic [31:0] y32, o32;
    logic        iv8, rdy8, m8, ov8, or8, f8;
    logic [7:0]  y8, o8;

    int unsigned n_vec;
    int unsigned n_err;

    incr_square_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .y(y32),
        .mode(m32), .out_valid(ov32), .out_ready(or32), .out(o32), .ovf(f32)
    );

    incr_square_seq #(.WIDTH(8), .OFFSET(8'd1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .y(y8),
        .mode(m8), .out_valid(ov8), .out_ready(or8), .out(o8), .ovf(f8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] g_out(input bit sel);
        return sel ? {24'h0, o8} : o32;
    endfunction
    function automatic logic [31:0] g_ovf(input bit sel);
        return sel ? 32'(f8) : 32'(f32);
    endfunction
    function automatic logic [31:0] g_ov(input bit sel);
        return sel ? 32'(ov8) : 32'(ov32);
    endfunction
    function automatic logic [31:0] g_rdy(input bit sel);
        return sel ? 32'(rdy8) : 32'(rdy32);
    endfunction

    task automatic drv(input bit sel, input logic v, input logic [31:0] yv, input logic md);
        if (sel) begin iv8 = v; y8 = yv[7:0]; m8 = md; end
        else begin iv32 = v; y32 = yv; m32 = md; end
    endtask
    task automatic drv_valid(input bit sel, input logic v);
        if (sel) iv8 = v; else iv32 = v;
    endtask
    task automatic drv_ordy(input bit sel, input logic r);
        if (sel) or8 = r; else or32 = r;
    endtask

    // Reference: plain integer arithmetic on the wrapped increment
    task automatic model(input int w, input logic [31:0] yv, input logic md,
                         output logic [31:0] eo, output logic eovf);
        longint unsigned mask, t, a, p;
        logic inc;
        mask = (64'd1 << w) - 64'd1;
        t    = (64'(yv) & mask) + 64'd1;
        a    = t & mask;
        inc  = (t >> w) != 64'd0;
        if (md) begin
            eo   = 32'(a);
            eovf = inc;
        end else begin
            p    = a * a;
            eo   = 32'(p & mask);
            eovf = inc | ((p >> w) != 64'd0);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction; starts and ends at a negedge with the unit idle
    task automatic run_op(input bit sel, input logic [31:0] yv, input logic md,
                          input int stall, input string tag);
        int w, lat;
        logic [31:0] eo;
        logic eovf;
        w   = sel ? 8 : 32;
        lat = md ? 0 : w;
        model(w, yv, md, eo, eovf);
        check({tag, ":idle_rdy"}, g_rdy(sel), 32'd1);
        drv(sel, 1'b1, yv, md);
        step();
        drv(sel, 1'b0, $urandom, ~md);
        for (int k = 0; k < lat; k++) begin
            check({tag, ":busy_ov"}, g_ov(sel), 32'd0);
            if (k == 0) check({tag, ":busy_rdy"}, g_rdy(sel), 32'd0);
            drv(sel, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        drv_valid(sel, 1'b0);
        check({tag, ":ov"}, g_ov(sel), 32'd1);
        check({tag, ":out"}, g_out(sel), eo);
        check({tag, ":ovf"}, g_ovf(sel), 32'(eovf));
        for (int s = 0; s < stall; s++) begin
            drv_valid(sel, 1'($urandom_range(0, 1)));
            step();
            check({tag, ":hold_ov"}, g_ov(sel), 32'd1);
            check({tag, ":hold_out"}, g_out(sel), eo);
            check({tag, ":hold_rdy"}, g_rdy(sel), 32'd0);
        end
        drv_valid(sel, 1'b0);
        drv_ordy(sel, 1'b1);
        step();
        drv_ordy(sel, 1'b0);
        check({tag, ":drain_ov"}, g_ov(sel), 32'd0);
        check({tag, ":drain_rdy"}, g_rdy(sel), 32'd1);
        check({tag, ":drain_out"}, g_out(sel), eo);
    endtask

    initial begin
        logic [31:0] ry;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drv(1'b0, 1'b0, 32'd0, 1'b0);
        drv(1'b1, 1'b0, 32'd0, 1'b0);
        or32 = 1'b0;
        or8  = 1'b0;
        @(negedge clk);
        step();
        check("rst_out", g_out(1'b0), 32'd0);
        check("rst_ovf", g_ovf(1'b0), 32'd0);
        check("rst_ov", g_ov(1'b0), 32'd0);
        check("rst_rdy", g_rdy(1'b0), 32'd1);
        check("rst8_ov", g_ov(1'b1), 32'd0);
        rst_n = 1'b1;

        run_op(1'b0, 32'd10, 1'b0, 0, "basic");
        check("basic_val", o32, 32'd121);
        run_op(1'b0, 32'd3, 1'b0, 10, "seq_bp");
        check("seq_val", o32, 32'd16);
        run_op(1'b0, 32'd7, 1'b0 ^ 1'b1, 0, "m1_7");
        check("m1_7_val", o32, 32'd8);
        run_op(1'b0, 32'hFFFF_FFFF, 1'b1, 1, "m1_max");
        run_op(1'b0, 32'd65536, 1'b0, 0, "ovf_64k");
        check("ovf_64k_val", o32, 32'd131073);
        run_op(1'b0, 32'hFFFF_FFFF, 1'b0, 0, "ovf_max");
        run_op(1'b0, 32'd65534, 1'b0, 2, "fit_edge");
        check("fit_edge_val", o32, 32'hFFFE_0001);

        // Reset after ten multiply steps discards the op
        drv(1'b0, 1'b1, 32'd12345, 1'b0);
        step();
        drv_valid(1'b0, 1'b0);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_ov", g_ov(1'b0), 32'd0);
        check("mid_rst_out", g_out(1'b0), 32'd0);
        check("mid_rst_ovf", g_ovf(1'b0), 32'd0);
        check("mid_rst_rdy", g_rdy(1'b0), 32'd1);
        run_op(1'b0, 32'd10, 1'b0, 0, "post_rst");
        check("post_rst_val", o32, 32'd121);

        run_op(1'b1, 32'd14, 1'b0, 0, "w8_basic");
        check("w8_basic_val", 32'(o8), 32'd225);
        run_op(1'b1, 32'd255, 1'b0, 0, "w8_max");
        run_op(1'b1, 32'd15, 1'b0, 0, "w8_ovf");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       ry = $urandom;
                1:       ry = $urandom_range(0, 300);
                2:       ry = 32'd65535 + 32'($urandom_range(0, 2)) - 32'd1;
                default: ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            run_op(1'(i & 1), ry, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
